// File: rtl/hazard_pkg.sv
// Shared constants and types for the Tuse/Tnew stall/bubble controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package hazard_pkg;

  // Cycles from D until a source operand is consumed.
  localparam logic [1:0] TUSE_D = 2'd0;  // branch compare / jr target
  localparam logic [1:0] TUSE_E = 2'd1;  // ALU operand
  localparam logic [1:0] TUSE_M = 2'd2;  // store data

  // Cycles after entering E until a result can be forwarded.
  localparam logic [1:0] TNEW_JAL  = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  // Mult/div operation select.
  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  // Shadow-stage record at the default widths (AW=5, TW=2). The top declares
  // the same {wr_en, addr, tnew} layout sized by its own parameters.
  typedef struct packed {
    logic       wr_en;
    logic [4:0] addr;
    logic [1:0] tnew;
  } shadow_t;

endpackage

// File: rtl/md_busy_counter.sv
// Busy counter for the multi-cycle mult/div unit.
// Latency: load takes effect on the next clock edge; busy is a pure decode of the count.
// Backpressure: none; the caller only pulses load for a start that actually advances.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   load        - start accepted this cycle
//   op          - MD_MULT / MD_DIV, selects the reload value
//   busy        - counter nonzero
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MDW         = 4,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic op,
  output logic busy
);

  localparam logic [MDW-1:0] MULT_LD = MDW'(MULT_CYCLES);
  localparam logic [MDW-1:0] DIV_LD  = MDW'(DIV_CYCLES);
  localparam logic [MDW-1:0] CNT_ONE = MDW'(1);

  logic [MDW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (op == MD_DIV) ? DIV_LD : MULT_LD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl_tn.sv
// Stall/bubble controller for the 5-stage pipeline using Tuse/Tnew classification.
// Latency: stall/flush_e are combinational from D inputs; shadow state updates on the clock edge.
// Backpressure: stall freezes PC and F/D; flush_e (identical) bubbles D/E in the same cycle.
//
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   d_*                         - decoded fields of the instruction in D
//   stall, flush_e              - freeze front end / insert E bubble
//   md_busy                     - mult/div unit still working
//   e_wr_addr/e_tnew, m_*       - shadow E/M destinations (addr 0 when no write)
//   stall_count                 - saturating count of stalled cycles
module hazard_ctrl_tn
  import hazard_pkg::*;
#(
  parameter int AW          = 5,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int MDW         = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [AW-1:0]    d_rs_addr,
  input  logic             d_rs_used,
  input  logic [TW-1:0]    d_rs_tuse,
  input  logic [AW-1:0]    d_rt_addr,
  input  logic             d_rt_used,
  input  logic [TW-1:0]    d_rt_tuse,
  input  logic             d_wr_en,
  input  logic [AW-1:0]    d_wr_addr,
  input  logic [TW-1:0]    d_tnew,
  input  logic             d_md_start,
  input  logic             d_md_op,
  input  logic             d_md_use,
  output logic             stall,
  output logic             flush_e,
  output logic             md_busy,
  output logic [AW-1:0]    e_wr_addr,
  output logic [TW-1:0]    e_tnew,
  output logic [AW-1:0]    m_wr_addr,
  output logic [TW-1:0]    m_tnew,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [TW-1:0] tnew;
  } stage_t;

  localparam logic [TW-1:0]    TNEW_ONE = TW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  stage_t e_q, e_d, m_q, m_d;
  logic   e_md_start_q;
  logic   data_hz, md_hz, md_load;

  // A source only conflicts with a producer whose result arrives later than
  // the source is needed. $0 is never a real dependency.
  function automatic logic src_hz(input logic used, input logic [AW-1:0] addr,
                                  input logic [TW-1:0] tuse, input stage_t st);
    return used && (addr != '0) && st.wr_en && (st.addr == addr) && (st.tnew > tuse);
  endfunction

  always_comb begin
    data_hz = src_hz(d_rs_used, d_rs_addr, d_rs_tuse, e_q) |
              src_hz(d_rs_used, d_rs_addr, d_rs_tuse, m_q) |
              src_hz(d_rt_used, d_rt_addr, d_rt_tuse, e_q) |
              src_hz(d_rt_used, d_rt_addr, d_rt_tuse, m_q);
    // e_md_start_q covers the cycle right after a start is accepted.
    md_hz   = (d_md_use | d_md_start) & (md_busy | e_md_start_q);
    stall   = d_valid & (data_hz | md_hz);
    flush_e = stall;
    md_load = d_valid & d_md_start & ~stall;
  end

  always_comb begin
    e_d = '0;
    if (!stall && d_valid && d_wr_en && (d_wr_addr != '0)) begin
      e_d.wr_en = 1'b1;
      e_d.addr  = d_wr_addr;
      e_d.tnew  = d_tnew;
    end
    m_d       = e_q;
    m_d.tnew  = (e_q.tnew == '0) ? '0 : (e_q.tnew - TNEW_ONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q          <= '0;
      m_q          <= '0;
      e_md_start_q <= 1'b0;
      stall_count  <= '0;
    end else begin
      e_q          <= e_d;
      m_q          <= m_d;
      e_md_start_q <= md_load;
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_ONE;
      end
    end
  end

  md_busy_counter #(
    .MDW         (MDW),
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (md_load),
    .op    (d_md_op),
    .busy  (md_busy)
  );

  assign e_wr_addr = e_q.addr;
  assign e_tnew    = e_q.tnew;
  assign m_wr_addr = m_q.addr;
  assign m_tnew    = m_q.tnew;

endmodule

// File: tb/tb_hazard_ctrl_tn.sv
// Testbench for hazard_ctrl_tn: directed instruction sequences with a scoreboard.
// Latency: expectations are pushed when D inputs are applied and popped on the same cycle's falling edge.
// Backpressure: the bench repeats a stalled instruction in D itself.
module tb_hazard_ctrl_tn;
  import hazard_pkg::*;

  localparam int CNT_W   = 4;  // narrow so saturation is reached
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             d_valid, d_rs_used, d_rt_used, d_wr_en, d_md_start, d_md_op, d_md_use;
  logic [4:0]       d_rs_addr, d_rt_addr, d_wr_addr;
  logic [1:0]       d_rs_tuse, d_rt_tuse, d_tnew;
  logic             stall, flush_e, md_busy;
  logic [4:0]       e_wr_addr, m_wr_addr;
  logic [1:0]       e_tnew, m_tnew;
  logic [CNT_W-1:0] stall_count;

  hazard_ctrl_tn #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs_addr(d_rs_addr), .d_rs_used(d_rs_used), .d_rs_tuse(d_rs_tuse),
    .d_rt_addr(d_rt_addr), .d_rt_used(d_rt_used), .d_rt_tuse(d_rt_tuse),
    .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_op(d_md_op), .d_md_use(d_md_use),
    .stall(stall), .flush_e(flush_e), .md_busy(md_busy),
    .e_wr_addr(e_wr_addr), .e_tnew(e_tnew), .m_wr_addr(m_wr_addr), .m_tnew(m_tnew),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rs; logic rs_u; logic [1:0] rs_t;
    logic [4:0] rt; logic rt_u; logic [1:0] rt_t;
    logic       wr; logic [4:0] wa; logic [1:0] tn;
    logic       mds; logic mdop; logic mdu;
  } dins_t;

  typedef struct {
    logic  stall;
    logic  busy;
    int    cnt;
    int    ea;   // -1 = not checked
    int    ma;
    string nm;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_cnt  = 0;

  // ---------------- instruction builders ----------------
  function automatic dins_t nop();
    return '0;
  endfunction
  function automatic dins_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    dins_t d = '0;
    d.v = 1; d.rs = rs; d.rs_u = 1; d.rs_t = TUSE_E; d.rt = rt; d.rt_u = 1; d.rt_t = TUSE_E;
    d.wr = 1; d.wa = rd; d.tn = TNEW_ALU;
    return d;
  endfunction
  function automatic dins_t lw(input logic [4:0] rt, input logic [4:0] base);
    dins_t d = '0;
    d.v = 1; d.rs = base; d.rs_u = 1; d.rs_t = TUSE_E; d.wr = 1; d.wa = rt; d.tn = TNEW_LOAD;
    return d;
  endfunction
  function automatic dins_t sw(input logic [4:0] rt, input logic [4:0] base);
    dins_t d = '0;
    d.v = 1; d.rs = base; d.rs_u = 1; d.rs_t = TUSE_E; d.rt = rt; d.rt_u = 1; d.rt_t = TUSE_M;
    return d;
  endfunction
  function automatic dins_t beq(input logic [4:0] rs, input logic [4:0] rt);
    dins_t d = '0;
    d.v = 1; d.rs = rs; d.rs_u = 1; d.rs_t = TUSE_D; d.rt = rt; d.rt_u = 1; d.rt_t = TUSE_D;
    return d;
  endfunction
  function automatic dins_t jr(input logic [4:0] rs);
    dins_t d = '0;
    d.v = 1; d.rs = rs; d.rs_u = 1; d.rs_t = TUSE_D;
    return d;
  endfunction
  function automatic dins_t md(input logic op, input logic [4:0] rs, input logic [4:0] rt);
    dins_t d = '0;
    d.v = 1; d.rs = rs; d.rs_u = 1; d.rs_t = TUSE_E; d.rt = rt; d.rt_u = 1; d.rt_t = TUSE_E;
    d.mds = 1; d.mdop = op;
    return d;
  endfunction
  function automatic dins_t mflo(input logic [4:0] rd);
    dins_t d = '0;
    d.v = 1; d.mdu = 1; d.wr = 1; d.wa = rd; d.tn = TNEW_ALU;
    return d;
  endfunction

  task automatic apply(input dins_t d);
    d_valid = d.v;
    d_rs_addr = d.rs; d_rs_used = d.rs_u; d_rs_tuse = d.rs_t;
    d_rt_addr = d.rt; d_rt_used = d.rt_u; d_rt_tuse = d.rt_t;
    d_wr_en = d.wr; d_wr_addr = d.wa; d_tnew = d.tn;
    d_md_start = d.mds; d_md_op = d.mdop; d_md_use = d.mdu;
  endtask

  // One pipeline cycle: present d in D and queue the expected response.
  task automatic cyc(input dins_t d, input logic es, input logic eb,
                     input int ea, input int ma, input string nm);
    exp_t x;
    @(posedge clk); #1;
    reset = 1'b0;
    apply(d);
    x.stall = es; x.busy = eb; x.cnt = exp_cnt; x.ea = ea; x.ma = ma; x.nm = nm;
    sbq.push_back(x);
    if (es && exp_cnt != CNT_MAX) exp_cnt++;
  endtask

  // Assert reset for one clock edge; D inputs are left as they were.
  task automatic do_reset();
    @(posedge clk); #1;
    reset   = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t x;
      x = sbq.pop_front();
      chk({x.nm, ".stall"},   int'(stall),       int'(x.stall));
      chk({x.nm, ".flush_e"}, int'(flush_e),     int'(x.stall));
      chk({x.nm, ".md_busy"}, int'(md_busy),     int'(x.busy));
      chk({x.nm, ".count"},   int'(stall_count), x.cnt);
      if (x.ea >= 0) chk({x.nm, ".e_addr"}, int'(e_wr_addr), x.ea);
      if (x.ma >= 0) chk({x.nm, ".m_addr"}, int'(m_wr_addr), x.ma);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  dins_t inv_beq, mix8;

  initial begin
    reset = 1'b1;
    apply(nop());
    repeat (3) @(posedge clk);

    cyc(nop(), 0, 0, 0, 0, "reset");

    // lw $8 then beq $8,$9: two stalls (E then M).
    cyc(lw(8, 29),  0, 0, -1, -1, "lw_a");
    cyc(beq(8, 9),  1, 0, 8, 0,   "beq_e");
    cyc(beq(8, 9),  1, 0, 0, 8,   "beq_m");
    cyc(beq(8, 9),  0, 0, 0, 0,   "beq_go");

    // lw $8 then add $3,$8,$4: one stall; then lw $8 / sw $8: none.
    cyc(lw(8, 29),    0, 0, -1, -1, "lw_b");
    cyc(alu(3, 8, 4), 1, 0, 8, -1,  "add_e");
    cyc(alu(3, 8, 4), 0, 0, 0, 8,   "add_go");
    cyc(lw(8, 29),    0, 0, 3, -1,  "lw_c");
    cyc(sw(8, 29),    0, 0, 8, -1,  "sw_nostall");

    // add $5 then jr $5: one stall. Destination $0 never hazards.
    cyc(alu(5, 1, 2), 0, 0, 0, 8,   "add5");
    cyc(jr(5),        1, 0, 5, -1,  "jr_e");
    cyc(jr(5),        0, 0, 0, 5,   "jr_go");
    cyc(alu(0, 1, 2), 0, 0, -1, -1, "add0");
    cyc(jr(0),        0, 0, 0, -1,  "jr0");

    // d_valid=0 with a conflicting beq: no stall, enters E as a bubble.
    inv_beq = beq(8, 9); inv_beq.v = 1'b0;
    mix8 = '0;
    mix8.v = 1; mix8.rs = 8; mix8.rs_u = 1; mix8.rs_t = TUSE_M;
    mix8.rt = 8; mix8.rt_u = 1; mix8.rt_t = TUSE_D;
    cyc(lw(8, 29), 0, 0, 0, -1, "lw_d");
    cyc(inv_beq,   0, 0, 8, -1, "invalid");
    // rs==rt with Tuse 2 and 0: the smaller one governs against lw in M.
    cyc(mix8,      1, 0, 0, 8,  "rs_eq_rt");
    cyc(mix8,      0, 0, 0, 0,  "rs_eq_rt_go");

    // div then mflo: stalls for the 10 busy cycles, then proceeds.
    cyc(md(MD_DIV, 1, 2), 0, 0, -1, -1, "div");
    for (int i = 0; i < 10; i++) cyc(mflo(4), 1, 1, -1, -1, $sformatf("mflo_wait%0d", i));
    cyc(mflo(4), 0, 0, -1, -1, "mflo_go");

    // mult then a second mult while busy: no reload until it advances.
    cyc(md(MD_MULT, 1, 2), 0, 0, 4, -1, "mult_a");
    for (int i = 0; i < 5; i++) cyc(md(MD_MULT, 1, 2), 1, 1, -1, -1, $sformatf("mult_wait%0d", i));
    cyc(md(MD_MULT, 1, 2), 0, 0, -1, -1, "mult_b_go");
    for (int i = 0; i < 5; i++) cyc(nop(), 0, 1, -1, -1, $sformatf("mult_busy%0d", i));

    // Reset in the middle of a divide with a stall active.
    cyc(md(MD_DIV, 1, 2), 0, 0, -1, -1, "div2");
    for (int i = 0; i < 3; i++) cyc(mflo(4), 1, 1, -1, -1, $sformatf("mflo2_wait%0d", i));
    do_reset();
    cyc(mflo(4), 0, 0, 0, 0, "rst_mid");
    cyc(nop(),   0, 0, 4, 0, "after_rst");

    repeat (2) @(negedge clk);
    if (sbq.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
